// File: rtl/bip_pkg.sv
// rtl/bip_pkg.sv - shared opcodes, source selects, flag indices and multiplier states
package bip_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;
  localparam logic [4:0] OP_AND  = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_ORI  = 5'b01011;
  localparam logic [4:0] OP_XOR  = 5'b01100;
  localparam logic [4:0] OP_XORI = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SRA  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;

  localparam logic [1:0] SELA_MEM  = 2'b00;
  localparam logic [1:0] SELA_IMM  = 2'b01;
  localparam logic [1:0] SELA_ALU  = 2'b10;
  localparam logic [1:0] SELA_HOLD = 2'b11;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } mult_state_t;

endpackage

// File: rtl/bip_datapath_ext_if.sv
// rtl/bip_datapath_ext_if.sv - control-unit / memory bus of the BIP datapath
interface bip_datapath_ext_if #(
  parameter int NB_DATA     = 16,
  parameter int NB_OPERANDO = 11,
  parameter int NB_OPCODE   = 5,
  parameter int NB_SEL_A    = 2
);
  logic [NB_SEL_A-1:0]    i_selA;
  logic                   i_selB;
  logic                   i_wrAcc;
  logic [NB_OPCODE-1:0]   i_op;
  logic [NB_OPERANDO-1:0] i_operando;
  logic [NB_DATA-1:0]     i_data;
  logic [NB_DATA-1:0]     o_data;
  logic [3:0]             o_flags;
  logic                   o_busy;
  logic                   o_done;

  modport master (
    output i_selA, i_selB, i_wrAcc, i_op, i_operando, i_data,
    input  o_data, o_flags, o_busy, o_done
  );

  modport slave (
    input  i_selA, i_selB, i_wrAcc, i_op, i_operando, i_data,
    output o_data, o_flags, o_busy, o_done
  );
endinterface

// File: rtl/bip_seq_mult.sv
// rtl/bip_seq_mult.sv - radix-2 shift-add signed multiplier, one bit per cycle
module bip_seq_mult
  import bip_pkg::*;
#(
  parameter int NB_DATA = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NB_DATA-1:0]     a,
  input  logic [NB_DATA-1:0]     b,
  output logic                   busy,
  output logic                   done,
  output logic [2*NB_DATA-1:0]   product
);
  localparam int CW = $clog2(NB_DATA + 1);

  mult_state_t state_q, state_d;
  logic [NB_DATA:0]     ext_a, ext_b, mag_a, mag_b;
  logic [NB_DATA:0]     mplier_q;
  logic [2*NB_DATA-1:0] mcand_q, prod_q;
  logic [CW-1:0]        cnt_q;
  logic                 sign_q;

  // magnitudes are one bit wider so the most-negative operand stays exact
  assign ext_a = {a[NB_DATA-1], a};
  assign ext_b = {b[NB_DATA-1], b};
  assign mag_a = ext_a[NB_DATA] ? (~ext_a + 1'b1) : ext_a;
  assign mag_b = ext_b[NB_DATA] ? (~ext_b + 1'b1) : ext_b;
  assign product = sign_q ? (~prod_q + 1'b1) : prod_q;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(NB_DATA - 1)) state_d = ST_FIN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // operand latch on start, then one shift-add step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else if (state_q == ST_IDLE && start) begin
      mcand_q  <= {{(NB_DATA-1){1'b0}}, mag_a};
      mplier_q <= mag_b;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= a[NB_DATA-1] ^ b[NB_DATA-1];
    end else if (state_q == ST_RUN) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/bip_datapath_ext.sv
// rtl/bip_datapath_ext.sv - BIP accumulator datapath with extended ALU, flags and multiplier
module bip_datapath_ext
  import bip_pkg::*;
#(
  parameter int NB_DATA     = 16,
  parameter int NB_OPERANDO = 11,
  parameter int NB_OPCODE   = 5,
  parameter int NB_SEL_A    = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  bip_datapath_ext_if.slave   bus
);
  localparam int MSB   = NB_DATA - 1;
  localparam int NB_SH = $clog2(NB_DATA);

  logic [NB_OPCODE-1:0] op;
  logic [NB_SEL_A-1:0]  sel_a;
  logic [NB_DATA-1:0]   acc_q, operand_ext, b, alu_res, mul_low;
  logic [NB_DATA:0]     sum, diff;
  logic [3:0]           flags_q, alu_flags;
  logic                 alu_c, alu_v, alu_known;
  logic                 accept, mul_start, mul_busy, mul_done, mul_ovf;
  logic [2*NB_DATA-1:0] mul_product;

  assign op          = bus.i_op;
  assign sel_a       = bus.i_selA;
  assign operand_ext = {{(NB_DATA-NB_OPERANDO){bus.i_operando[NB_OPERANDO-1]}}, bus.i_operando};
  assign b           = bus.i_selB ? operand_ext : bus.i_data;
  assign sum         = {1'b0, acc_q} + {1'b0, b};
  assign diff        = {1'b0, acc_q} - {1'b0, b};

  // combinational ALU on acc and B; carry/overflow only meaningful for add/sub
  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_known = 1'b1;
    case (op)
      OP_ADD, OP_ADDI: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[NB_DATA];
        alu_v   = (acc_q[MSB] == b[MSB]) && (alu_res[MSB] != acc_q[MSB]);
      end
      OP_SUB, OP_SUBI: begin
        alu_res = diff[MSB:0];
        alu_c   = diff[NB_DATA];
        alu_v   = (acc_q[MSB] != b[MSB]) && (alu_res[MSB] != acc_q[MSB]);
      end
      OP_AND, OP_ANDI: alu_res = acc_q & b;
      OP_OR,  OP_ORI:  alu_res = acc_q | b;
      OP_XOR, OP_XORI: alu_res = acc_q ^ b;
      OP_SLL:          alu_res = acc_q << b[NB_SH-1:0];
      OP_SRA:          alu_res = $unsigned($signed(acc_q) >>> b[NB_SH-1:0]);
      default:         alu_known = 1'b0;
    endcase
  end

  assign alu_flags = alu_known ? {alu_res == '0, alu_res[MSB], alu_c, alu_v} : 4'b0000;

  // writes are refused for the whole multiply, including the cycle the product lands
  assign accept    = bus.i_wrAcc && !mul_busy && !mul_done;
  assign mul_start = accept && (sel_a == SELA_ALU) && (op == OP_MUL);
  assign mul_low   = mul_product[MSB:0];
  assign mul_ovf   = mul_product != {{NB_DATA{mul_low[MSB]}}, mul_low};

  bip_seq_mult #(.NB_DATA(NB_DATA)) u_mult (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .start   (mul_start),
    .a       (acc_q),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // accumulator and flags: product write-back first, else the selected single-cycle source
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      acc_q   <= '0;
      flags_q <= '0;
    end else if (mul_done) begin
      acc_q           <= mul_low;
      flags_q[FLAG_Z] <= (mul_low == '0);
      flags_q[FLAG_N] <= mul_low[MSB];
      flags_q[FLAG_C] <= 1'b0;
      flags_q[FLAG_V] <= mul_ovf;
    end else if (accept && !mul_start) begin
      case (sel_a)
        SELA_MEM: acc_q <= bus.i_data;
        SELA_IMM: acc_q <= operand_ext;
        SELA_ALU: begin
          acc_q   <= alu_res;
          flags_q <= alu_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_data  = acc_q;
  assign bus.o_flags = flags_q;
  assign bus.o_busy  = mul_busy;
  assign bus.o_done  = mul_done;
endmodule

// File: tb/tb_bip_datapath_ext.sv
// tb/tb_bip_datapath_ext.sv - self-checking bench for bip_datapath_ext
module tb_bip_datapath_ext;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] macc = '0;
  logic [3:0]  mflags = '0;

  bip_datapath_ext_if #(.NB_DATA(16), .NB_OPERANDO(11), .NB_OPCODE(5), .NB_SEL_A(2)) bus ();

  bip_datapath_ext #(.NB_DATA(16), .NB_OPERANDO(11), .NB_OPCODE(5), .NB_SEL_A(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sext(input logic [10:0] imm);
    return {{5{imm[10]}}, imm};
  endfunction

  function automatic void ref_alu(input logic [4:0] op, input logic [15:0] a, input logic [15:0] bb,
                                  output logic [15:0] r, output logic [3:0] f);
    int ua, ub, sa, sb, t;
    logic c, v, known;
    ua = int'(a); ub = int'(bb);
    sa = int'($signed(a)); sb = int'($signed(bb));
    c = 1'b0; v = 1'b0; known = 1'b1; t = 0;
    case (op)
      5'd4, 5'd5: begin t = ua + ub; c = (t > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
      5'd6, 5'd7: begin t = ua - ub; c = (ua < ub);   v = (sa - sb > 32767) || (sa - sb < -32768); end
      5'd8, 5'd9:   t = ua & ub;
      5'd10, 5'd11: t = ua | ub;
      5'd12, 5'd13: t = ua ^ ub;
      5'd14: t = ua << (ub % 16);
      5'd15: t = sa >>> (ub % 16);
      default: known = 1'b0;
    endcase
    r = known ? t[15:0] : 16'h0000;
    f = known ? {r == 16'h0, r[15], c, v} : 4'b0000;
  endfunction

  task automatic wr(input string tag, input logic [1:0] sel_a, input logic sel_b, input logic [4:0] op,
                    input logic [10:0] imm, input logic [15:0] data);
    logic [15:0] bb, r;
    logic [3:0] f;
    bus.i_selA = sel_a; bus.i_selB = sel_b; bus.i_op = op;
    bus.i_operando = imm; bus.i_data = data; bus.i_wrAcc = 1'b1;
    @(posedge clk); #1;
    bus.i_wrAcc = 1'b0;
    bb = sel_b ? sext(imm) : data;
    case (sel_a)
      2'b00: macc = data;
      2'b01: macc = sext(imm);
      2'b10: begin ref_alu(op, macc, bb, r, f); macc = r; mflags = f; end
      default: ;
    endcase
    check({tag, "_acc"}, 32'(bus.o_data), 32'(macc));
    check({tag, "_flags"}, 32'(bus.o_flags), 32'(mflags));
  endtask

  task automatic mul(input string tag, input logic sel_b, input logic [10:0] imm, input logic [15:0] data,
                     input bit noisy);
    longint p;
    int n;
    logic [15:0] r;
    p = longint'($signed(macc)) * longint'($signed(sel_b ? sext(imm) : data));
    bus.i_selA = 2'b10; bus.i_selB = sel_b; bus.i_op = 5'd16;
    bus.i_operando = imm; bus.i_data = data; bus.i_wrAcc = 1'b1;
    @(posedge clk); #1;
    if (noisy) begin
      bus.i_selA = 2'b00; bus.i_selB = 1'b0; bus.i_data = 16'h1234;
    end else begin
      bus.i_wrAcc = 1'b0;
    end
    n = 0;
    while (bus.o_busy === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    bus.i_wrAcc = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'd16);
    check({tag, "_done_pulse"}, 32'(bus.o_done), 32'd1);
    check({tag, "_acc_held"}, 32'(bus.o_data), 32'(macc));
    @(posedge clk); #1;
    r = p[15:0];
    macc = r;
    mflags = {r == 16'h0, r[15], 1'b0, (p > 32767) || (p < -32768)};
    check({tag, "_acc"}, 32'(bus.o_data), 32'(macc));
    check({tag, "_flags"}, 32'(bus.o_flags), 32'(mflags));
    check({tag, "_done_off"}, 32'(bus.o_done), 32'd0);
  endtask

  initial begin
    bus.i_selA = '0; bus.i_selB = 1'b0; bus.i_wrAcc = 1'b0;
    bus.i_op = '0; bus.i_operando = '0; bus.i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_acc", 32'(bus.o_data), 32'd0);
    check("rst_flags", 32'(bus.o_flags), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    wr("ld_7fff", 2'b00, 1'b0, 5'd0, 11'd0, 16'h7FFF);
    wr("addi_ovf", 2'b10, 1'b1, 5'd5, 11'd1, 16'h0);
    check("addi_ovf_const", 32'({bus.o_data, bus.o_flags}), 32'h8000_5);

    wr("ld_5", 2'b00, 1'b0, 5'd0, 11'd0, 16'd5);
    wr("sub_borrow", 2'b10, 1'b0, 5'd6, 11'd0, 16'd7);
    check("sub_borrow_const", 32'({bus.o_data, bus.o_flags}), 32'hFFFE_6);
    wr("subi_zero", 2'b10, 1'b1, 5'd7, 11'h7FE, 16'h0);
    check("subi_zero_const", 32'({bus.o_data, bus.o_flags}), 32'h0000_8);

    wr("ld_8001", 2'b00, 1'b0, 5'd0, 11'd0, 16'h8001);
    wr("sra1", 2'b10, 1'b1, 5'd15, 11'd1, 16'h0);
    check("sra1_const", 32'(bus.o_data), 32'hC000);
    wr("ld_3", 2'b01, 1'b0, 5'd0, 11'd3, 16'h0);
    wr("sll15", 2'b10, 1'b1, 5'd14, 11'd15, 16'h0);
    check("sll15_const", 32'({bus.o_data, bus.o_flags}), 32'h8000_4);
    wr("ld_keeps_flags", 2'b00, 1'b0, 5'd4, 11'd0, 16'h0000);
    check("ld_keeps_flags_const", 32'(bus.o_flags), 32'h4);
    wr("hold", 2'b11, 1'b0, 5'd4, 11'd0, 16'h5555);
    wr("bad_op", 2'b10, 1'b0, 5'd3, 11'd0, 16'h0);

    wr("ld_m3", 2'b00, 1'b0, 5'd0, 11'd0, 16'hFFFD);
    mul("mul_m3x7", 1'b0, 11'd0, 16'd7, 1'b0);
    check("mul_m3x7_const", 32'({bus.o_data, bus.o_flags}), 32'hFFEB_4);
    wr("ld_4000", 2'b00, 1'b0, 5'd0, 11'd0, 16'h4000);
    mul("mul_ovf", 1'b1, 11'd4, 16'h0, 1'b0);
    check("mul_ovf_const", 32'({bus.o_data, bus.o_flags}), 32'h0000_9);
    wr("ld_m5", 2'b01, 1'b0, 5'd0, 11'h7FB, 16'h0);
    mul("mul_lockout", 1'b0, 11'd0, 16'd9, 1'b1);
    check("mul_lockout_const", 32'(bus.o_data), 32'hFFD3);
    wr("ld_8000a", 2'b00, 1'b0, 5'd0, 11'd0, 16'h8000);
    mul("mul_minxmin", 1'b0, 11'd0, 16'h8000, 1'b0);
    wr("ld_8000b", 2'b00, 1'b0, 5'd0, 11'd0, 16'h8000);
    mul("mul_minxm1", 1'b1, 11'h7FF, 16'h0, 1'b1);
    wr("ld_1234", 2'b00, 1'b0, 5'd0, 11'd0, 16'h1234);
    mul("mul_by0", 1'b0, 11'd0, 16'h0, 1'b0);
    check("mul_by0_const", 32'(bus.o_flags), 32'h8);

    wr("ld_m3r", 2'b00, 1'b0, 5'd0, 11'd0, 16'hFFFD);
    wr("pre_rst_flags", 2'b10, 1'b1, 5'd5, 11'd0, 16'h0);
    bus.i_selA = 2'b10; bus.i_op = 5'd16; bus.i_selB = 1'b0; bus.i_data = 16'd7; bus.i_wrAcc = 1'b1;
    @(posedge clk); #1;
    bus.i_wrAcc = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(bus.o_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("midrst_acc", 32'(bus.o_data), 32'd0);
    check("midrst_flags", 32'(bus.o_flags), 32'd0);
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_done", 32'(bus.o_done), 32'd0);
    macc = '0; mflags = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("postrst_busy", 32'(bus.o_busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0] rop;
      if (i % 4 == 0) wr("rnd_ld", 2'b00, 1'b0, 5'd0, 11'd0, 16'($urandom));
      rop = 5'($urandom_range(0, 31));
      if (rop == 5'd16) rop = 5'd6;
      if (i % 7 == 3)
        wr("rnd_hold", 2'b11, 1'($urandom), rop, 11'($urandom), 16'($urandom));
      else
        wr("rnd_alu", 2'b10, 1'($urandom), rop, 11'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      wr("rnd_mld", 2'b00, 1'b0, 5'd0, 11'd0, 16'($urandom));
      mul("rnd_mul", 1'($urandom), 11'($urandom), 16'($urandom), (i % 2) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
